// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse conditioning path.
// MOUSE_ACCUM_FRAC_EN adds one fractional accumulator bit.
package mouse_pkg;

`ifdef MOUSE_ACCUM_FRAC_EN
    localparam int unsigned FRAC_BITS = 1;
`else
    localparam int unsigned FRAC_BITS = 0;
`endif

    localparam int unsigned EMIT_SAT        = 255;
    localparam int unsigned DELTA_W         = 9;
    localparam int unsigned ACC_MAX_DEFAULT = 1023;

    typedef enum logic [1:0] {
        SpdX1   = 2'd0,
        SpdX2   = 2'd1,
        SpdX4   = 2'd2,
        SpdHalf = 2'd3
    } speed_e;

    typedef struct packed {
        logic       tog;
        logic [7:0] dy;
        logic [7:0] dx;
        logic [1:0] rsv_hi;
        logic       sy;
        logic       sx;
        logic       rsv_lo;
        logic [2:0] btn;
    } mouse_bus_t;

    // Signed integer range +-acc_max plus the optional fraction bit.
    function automatic int unsigned acc_width(input int unsigned acc_max);
        return $clog2(acc_max + 1) + 1 + FRAC_BITS;
    endfunction

    localparam int unsigned ACC_W = acc_width(ACC_MAX_DEFAULT);

endpackage

// File: rtl/mouse_axis.sv
// One motion axis: scales incoming deltas, saturates the accumulator and
// hands out a clamped emission step while keeping the residual.
module mouse_axis
    import mouse_pkg::*;
#(
    parameter int unsigned ACC_MAX = ACC_MAX_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [DELTA_W-1:0] delta_i,
    input  logic               stb_i,
    input  speed_e             speed_i,
    input  logic               emit_i,
    output logic [DELTA_W-1:0] e_o,
    output logic               nz_o
);

    localparam int unsigned AccW = acc_width(ACC_MAX);
    localparam int unsigned ScW  = DELTA_W + 2 + FRAC_BITS;
    localparam int unsigned SumW = ((AccW > ScW) ? AccW : ScW) + 2;

    localparam logic signed [SumW-1:0] ESat   = SumW'(EMIT_SAT);
    localparam logic signed [SumW-1:0] AccLim = SumW'(ACC_MAX << FRAC_BITS);

    logic signed [AccW-1:0] acc_q, acc_d;
    logic signed [SumW-1:0] acc_x;
    logic signed [SumW-1:0] dlt_x;
    logic signed [SumW-1:0] scaled;
    logic signed [SumW-1:0] ip;
    logic signed [SumW-1:0] e_x;
    logic signed [SumW-1:0] sum;

    assign acc_x = {{(SumW - AccW){acc_q[AccW-1]}}, acc_q};
    assign dlt_x = {{(SumW - DELTA_W){delta_i[DELTA_W-1]}}, delta_i} <<< FRAC_BITS;

    always_comb begin
        scaled = dlt_x;
        unique case (speed_i)
            SpdX2:   scaled = dlt_x <<< 1;
            SpdX4:   scaled = dlt_x <<< 2;
            SpdHalf: scaled = dlt_x >>> 1;
            default: scaled = dlt_x;
        endcase
    end

`ifdef MOUSE_ACCUM_FRAC_EN
    // Truncate toward zero so a lone half count never reads as motion either way.
    always_comb begin
        ip = acc_x >>> 1;
        if (acc_x[SumW-1] && acc_x[0]) begin
            ip = ip + SumW'(1);
        end
    end
`else
    assign ip = acc_x;
`endif

    always_comb begin
        e_x = ip;
        if (ip > ESat) begin
            e_x = ESat;
        end else if (ip < -ESat) begin
            e_x = -ESat;
        end

        // Emission uses the pre-add value; the new delta lands in the residual.
        sum = acc_x;
        if (emit_i) begin
            sum = sum - (e_x <<< FRAC_BITS);
        end
        if (stb_i) begin
            sum = sum + scaled;
        end
        if (sum > AccLim) begin
            sum = AccLim;
        end else if (sum < -AccLim) begin
            sum = -AccLim;
        end
        acc_d = sum[AccW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign e_o  = e_x[DELTA_W-1:0];
    assign nz_o = (ip != '0);

endmodule

// File: rtl/mouse_accum.sv
// Host mouse packet accumulator feeding the port I/O MOUSE bus at a bounded rate.
// Build option: MOUSE_ACCUM_FRAC_EN keeps half counts from the x1/2 speed setting.
module mouse_accum
    import mouse_pkg::*;
#(
    parameter int unsigned EMIT_DIV = 2000,
    parameter int unsigned ACC_MAX  = ACC_MAX_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    input  logic [24:0] PS2_MOUSE,
    input  logic [1:0]  SPEED,
    output logic [24:0] MOUSE,
    output logic        PEND
);

    localparam int unsigned TmrW = $clog2(EMIT_DIV);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(EMIT_DIV - 1);

    mouse_bus_t in_bus;
    mouse_bus_t mouse_q, mouse_d;
    logic                stb_q;
    logic [TmrW-1:0]     timer_q, timer_d;
    logic [2:0]          btn_q, btn_d;
    logic                pkt;
    logic                tick_last;
    logic                emit;
    logic [DELTA_W-1:0]  dx, dy;
    logic [DELTA_W-1:0]  ex, ey;
    logic                nz_x, nz_y;
    speed_e              spd;
    logic                unused_rsv;

    assign in_bus     = mouse_bus_t'(PS2_MOUSE);
    assign unused_rsv = ^{in_bus.rsv_hi, in_bus.rsv_lo};
    assign pkt        = in_bus.tog ^ stb_q;
    assign dx         = {in_bus.sx, in_bus.dx};
    assign dy         = {in_bus.sy, in_bus.dy};
    assign spd        = speed_e'(SPEED);

    mouse_axis #(
        .ACC_MAX (ACC_MAX)
    ) u_axis_x (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .delta_i (dx),
        .stb_i   (pkt),
        .speed_i (spd),
        .emit_i  (emit),
        .e_o     (ex),
        .nz_o    (nz_x)
    );

    mouse_axis #(
        .ACC_MAX (ACC_MAX)
    ) u_axis_y (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .delta_i (dy),
        .stb_i   (pkt),
        .speed_i (spd),
        .emit_i  (emit),
        .e_o     (ey),
        .nz_o    (nz_y)
    );

    assign tick_last = CE && (timer_q == TmrLast);
    assign emit      = tick_last && (nz_x || nz_y || (btn_q != mouse_q.btn));

    always_comb begin
        timer_d = timer_q;
        if (CE) begin
            timer_d = tick_last ? '0 : timer_q + TmrW'(1);
        end

        btn_d = pkt ? in_bus.btn : btn_q;

        mouse_d = mouse_q;
        if (emit) begin
            mouse_d.tog    = ~mouse_q.tog;
            mouse_d.dy     = ey[7:0];
            mouse_d.dx     = ex[7:0];
            mouse_d.rsv_hi = 2'b00;
            mouse_d.sy     = ey[8];
            mouse_d.sx     = ex[8];
            mouse_d.rsv_lo = 1'b0;
            mouse_d.btn    = btn_q;
        end
    end

    // The strobe follows the input even in reset so no phantom packet appears afterwards.
    always_ff @(posedge CLK) begin
        stb_q <= in_bus.tog;
        if (RESET) begin
            timer_q <= '0;
            btn_q   <= '0;
            mouse_q <= '0;
        end else begin
            timer_q <= timer_d;
            btn_q   <= btn_d;
            mouse_q <= mouse_d;
        end
    end

    assign MOUSE = mouse_q;
    assign PEND  = nz_x | nz_y;

endmodule

// File: doc/mouse_accum.md
# mouse_accum

Conditions raw host mouse packets into the 25-bit mouse bus consumed by the controller-port I/O block. It accumulates per-axis deltas from host packets arriving at any rate, applies a speed scale and saturation, and re-emits at most one packet per emission interval. Residual motion is carried forward, so no movement is lost when host packets arrive faster than the emission rate. It sits between the host input interface and the port I/O block's `MOUSE` input.

## Interface
Parameters:
- `EMIT_DIV`, 2000: number of CE ticks between emission opportunities; must be ≥2.
- `ACC_MAX`, 1023: integer saturation magnitude of each accumulator.

Ports:
- `CLK` in 1: system clock.
- `RESET` in 1: synchronous, active-high reset.
- `CE` in 1: clock enable; only emission timing is gated by it.
- `PS2_MOUSE` in 25: host packet. [24] toggles once per packet; [23:16] dy low byte; [15:8] dx low byte; [5] dy sign; [4] dx sign; [2:0] buttons {M,R,L}.
- `SPEED` in 2: scale. 0 = ×1, 1 = ×2, 2 = ×4, 3 = ×½.
- `MOUSE` out 25: to the port I/O block. Same field layout as `PS2_MOUSE`; [24] toggles once per emission; [7:6] and [3] are always 0.
- `PEND` out 1: high when either accumulator holds a nonzero integer part.

## Operation
- **Packet detect:** `stb_q` holds the last sampled `PS2_MOUSE[24]`. A packet is seen when `PS2_MOUSE[24] != stb_q`. Detection is independent of CE.
- **Delta decode:** delta = 9-bit signed {sign, byte}, sign-extended to the accumulator width.
- **Scaling:**
  - ×2 and ×4 use a left shift.
  - ×½ uses an arithmetic right shift (see Configuration for handling of the dropped bit).
- **Accumulate:** acc ← clamp(acc + scaled, −ACC_MAX, +ACC_MAX) on the integer part.
- **Button latch:** buttons are latched on every packet into `btn_q`.
- **Emission:** occurs on a CE tick where the timer equals EMIT_DIV−1 (the timer then returns to 0) and at least one of the following holds:
  - either integer acc part is nonzero, or
  - `btn_q` differs from the last emitted buttons.
- **Emitted value:** per axis, e = clamp(int(acc), −255, +255). `MOUSE` [15:8]/[4] (x) and [23:16]/[5] (y) carry the 9-bit two's complement of e. [2:0] = `btn_q`. [24] inverts.
- **Residual:** acc ← acc − e, keeping any fraction. Excess beyond ±255 drains over subsequent emissions.
- **Same-cycle packet and emission:** e is computed from the pre-add acc, and the next acc = clamp(acc − e + scaled). No delta is dropped and none is counted twice.
- **No emission due:** the tick passes silently and `MOUSE` holds its value.
- **SPEED changes:** take effect on the next packet. Accumulated value is not rescaled.

## Timing
- **Reset values:** `MOUSE` = 0, `PEND` = 0, acc = 0, `btn_q` = 0, timer = 0. `stb_q` ← `PS2_MOUSE[24]`, so no spurious packet follows reset.
- **Reset mid-operation:** pending motion is discarded and the timer restarts.
- **Packet → acc/PEND:** 1 CLK.
- **Emission → `MOUSE` visible:** registered, 1 CLK after the qualifying CE edge.
- **Throughput:** at most one emission per EMIT_DIV CE ticks; at most one packet accepted per CLK.
- **Back-to-back packets:** two toggles on consecutive CLKs are both accepted.

## Configuration
- **`MOUSE_ACCUM_FRAC_EN` defined:**
  - Accumulators carry 1 fractional bit.
  - ×½ keeps the shifted-out bit as the fraction, so two +1 packets yield +1.
  - `PEND` and emission consider the integer part only.
- **Not defined:**
  - No fractional bit.
  - ×½ truncates toward −∞: +1 → 0, −1 → −1.
  - All other behaviour is identical.

## Structure
- **Package `mouse_pkg`:**
  - packed struct typedef for the 25-bit bus fields;
  - enum for `SPEED` codes;
  - constant `EMIT_SAT` = 255;
  - accumulator width localparam, derived from `ACC_MAX` and the FRAC macro.
- **Sub-module `mouse_axis`:** instantiated twice (x, y).
  - Inputs: delta, packet strobe, speed, emit.
  - Outputs: e, nonzero flag.
  - Contains the accumulator, scaling, clamp and residual logic.
- **Top level:** strobe detect, timer, button latch and bus assembly.

## Test plan
- **Single packet:** after reset, one packet dx=+10, dy=−3, L pressed, SPEED=0 → at the next emission tick `MOUSE[15:8]`=0x0A, [4]=0, [23:16]=0xFD, [5]=1, [2:0]=001, [24]=1; `PEND`=0 afterwards.
- **Drain over emissions:** five packets of dx=+200 within one interval → emissions of +255, +255, +255, +235, then no further toggle; acc saturation not reached.
- **Saturation:** ten packets of dx=−255 at SPEED=2 → acc clamps at −1023 → emissions −255, −255, −255, −255, −3.
- **Same-cycle collision:** packet dx=+7 arrives on the emission cycle with acc=+5 → this emission carries +5; the next carries +7.
- **Half speed:** SPEED=3 with three dx=+1 packets → with the FRAC macro, +1 emitted (fraction 0.5 retained); without it, no emission.
- **Buttons only and idle:** a button-only change (dx=dy=0, R pressed) → one emission with [2:0]=010 and zero deltas. No packets for 3 intervals → `MOUSE` unchanged, no toggles.
